// File: rtl/fetch_align_queue.sv
// Fetch alignment queue: slices an L0 cacheline into 32-bit instructions from the fetch PC
// up to and including the first branch, queues them, and presents up to SUPER_SCALAR_WIDTH per cycle.
module fetch_align_queue #(
  parameter int SUPER_SCALAR_WIDTH = 4,
  parameter int CACHE_LINE_BYTES   = 64,
  parameter int QUEUE_DEPTH        = 16
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [CACHE_LINE_BYTES*8-1:0]      line_in,
  input  logic                               line_valid_in,
  input  logic [63:0]                        line_pc_in,
  input  logic [63:0]                        line_pred_pc_in,
  output logic                               line_ready_out,
  input  logic                               flush_in,
  output logic [SUPER_SCALAR_WIDTH*32-1:0]   dec_instr_out,
  output logic [SUPER_SCALAR_WIDTH*64-1:0]   dec_pc_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]      dec_valid_out,
  output logic [SUPER_SCALAR_WIDTH-1:0]      dec_is_branch_out,
  output logic [SUPER_SCALAR_WIDTH*64-1:0]   dec_pred_pc_out,
  input  logic                               dec_ready_in,
  output logic [$clog2(QUEUE_DEPTH):0]       count_out,
  output logic                               misalign_err_out
);

  localparam int INSTRS_PER_LINE = CACHE_LINE_BYTES / 4;
  localparam int OFF_BITS        = $clog2(CACHE_LINE_BYTES);
  localparam int IDX_W           = OFF_BITS - 2;
  localparam int PTR_W           = $clog2(QUEUE_DEPTH);
  localparam int CNT_W           = PTR_W + 1;

  function automatic logic is_branch(input logic [31:0] w);
    return (w[31:26] == 6'b000101) ||
           (w[31:26] == 6'b100101) ||
           (w[31:24] == 8'b01010100) ||
           ((w[31:10] == 22'b1101011001011111000000) && (w[4:0] == 5'b00000));
  endfunction

  logic [31:0]      q_instr_p1 [QUEUE_DEPTH];
  logic [63:0]      q_pc_p1    [QUEUE_DEPTH];
  logic [63:0]      q_pred_p1  [QUEUE_DEPTH];
  logic             q_br_p1    [QUEUE_DEPTH];
  logic [PTR_W-1:0] head_p1, tail_p1;
  logic [CNT_W-1:0] cnt_p1;
  logic             mis_p1;

  logic [31:0]      word_p0 [INSTRS_PER_LINE];
  logic [63:0]      pc_p0   [INSTRS_PER_LINE];
  logic [63:0]      pred_p0 [INSTRS_PER_LINE];
  logic             br_p0   [INSTRS_PER_LINE];
  logic [IDX_W-1:0] off_p0  [INSTRS_PER_LINE];
  logic [PTR_W-1:0] slot_p0 [INSTRS_PER_LINE];
  logic [INSTRS_PER_LINE-1:0] vld_p0;
  logic [IDX_W-1:0] k0_p0;
  logic [CNT_W-1:0] n_push_p0, n_pop_p0;
  logic             stop_p0, acc_p0, aligned_p0, push_p0;
  logic [PTR_W-1:0] rd_idx;

  // Stage p0: slice the presented line and decide what enters the queue this cycle
  assign k0_p0      = line_pc_in[OFF_BITS-1:2];
  assign aligned_p0 = (line_pc_in[1:0] == 2'b00);
  assign line_ready_out = !rst_in && !flush_in &&
                          ((CNT_W'(QUEUE_DEPTH) - cnt_p1) >= CNT_W'(INSTRS_PER_LINE));
  assign acc_p0  = line_valid_in && line_ready_out;
  assign push_p0 = acc_p0 && aligned_p0;

  always_comb begin
    stop_p0   = 1'b0;
    n_push_p0 = '0;
    vld_p0    = '0;
    for (int k = 0; k < INSTRS_PER_LINE; k++) begin
      word_p0[k] = line_in[32*k +: 32];
      pc_p0[k]   = {line_pc_in[63:OFF_BITS], IDX_W'(k), 2'b00};
      br_p0[k]   = is_branch(word_p0[k]);
      pred_p0[k] = br_p0[k] ? line_pred_pc_in : pc_p0[k] + 64'd4;
      off_p0[k]  = IDX_W'(k) - k0_p0;
      slot_p0[k] = tail_p1 + PTR_W'(off_p0[k]);
      // Words before the fetch PC and after the first taken-path branch are dropped
      if ((IDX_W'(k) >= k0_p0) && !stop_p0) begin
        vld_p0[k] = 1'b1;
        stop_p0   = br_p0[k];
        n_push_p0 = n_push_p0 + CNT_W'(1);
      end
    end
  end

  always_comb begin
    n_pop_p0 = '0;
    if (dec_ready_in && !flush_in)
      n_pop_p0 = (cnt_p1 < CNT_W'(SUPER_SCALAR_WIDTH)) ? cnt_p1 : CNT_W'(SUPER_SCALAR_WIDTH);
  end

  // Stage p1: queue storage (data only, never reset) and pointer/count control
  always_ff @(posedge clk_in) begin
    if (push_p0) begin
      for (int k = 0; k < INSTRS_PER_LINE; k++) begin
        if (vld_p0[k]) begin
          q_instr_p1[slot_p0[k]] <= word_p0[k];
          q_pc_p1[slot_p0[k]]    <= pc_p0[k];
          q_pred_p1[slot_p0[k]]  <= pred_p0[k];
          q_br_p1[slot_p0[k]]    <= br_p0[k];
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || flush_in) begin
      head_p1 <= '0;
      tail_p1 <= '0;
      cnt_p1  <= '0;
      mis_p1  <= 1'b0;
    end else begin
      head_p1 <= head_p1 + PTR_W'(n_pop_p0);
      tail_p1 <= push_p0 ? tail_p1 + PTR_W'(n_push_p0) : tail_p1;
      cnt_p1  <= cnt_p1 + (push_p0 ? n_push_p0 : '0) - n_pop_p0;
      mis_p1  <= acc_p0 && !aligned_p0;
    end
  end

  assign count_out        = cnt_p1;
  assign misalign_err_out = mis_p1;

  always_comb begin
    dec_valid_out     = '0;
    dec_instr_out     = '0;
    dec_pc_out        = '0;
    dec_is_branch_out = '0;
    dec_pred_pc_out   = '0;
    rd_idx            = '0;
    for (int i = 0; i < SUPER_SCALAR_WIDTH; i++) begin
      rd_idx = head_p1 + PTR_W'(i);
      if (CNT_W'(i) < cnt_p1) begin
        dec_valid_out[i]          = 1'b1;
        dec_instr_out[32*i +: 32] = q_instr_p1[rd_idx];
        dec_pc_out[64*i +: 64]    = q_pc_p1[rd_idx];
        dec_is_branch_out[i]      = q_br_p1[rd_idx];
        dec_pred_pc_out[64*i +: 64] = q_pred_p1[rd_idx];
      end
    end
  end

endmodule
